// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver front end for the serial debug path.
//
// Ports:
//   clk       system clock, rising edge
//   rstn      synchronous active-low reset
//   rxd       asynchronous serial line, idles high, LSB first
//   dout      received byte, stable while dout_vld is high
//   dout_vld  byte available, held until accepted
//   dout_rdy  consumer accepts dout on an edge with dout_vld & dout_rdy
//   busy      receiver is inside a frame (any state but IDLE)
//   ferr      one-cycle pulse, stop bit sampled low (byte discarded)
//   ovr       one-cycle pulse, byte completed while previous one still held
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for rxd_s low (start bit edge)
// START | timing half a bit to re-check the start bit at its centre
// DATA  | sampling 8 data bits at bit centres, LSB first
// STOP  | sampling the stop bit, then deliver / flag ferr / flag ovr
module uart_rx_byte #(
   parameter int DIV = 868
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxd,
   output logic [7:0] dout,
   output logic       dout_vld,
   input  logic       dout_rdy,
   output logic       busy,
   output logic       ferr,
   output logic       ovr
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   // Bit timer counts down to zero; the reload value sets the interval.
   localparam logic [CW-1:0] HALF_TC = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_TC = CW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic          s1, rxd_s;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic [7:0]    dout_nxt;
   logic          dout_vld_nxt, ferr_nxt, ovr_nxt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1       <= 1'b1;
         rxd_s    <= 1'b1;
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         dout     <= '0;
         dout_vld <= 1'b0;
         ferr     <= 1'b0;
         ovr      <= 1'b0;
      end else begin
         s1       <= rxd;
         rxd_s    <= s1;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         shreg    <= shreg_nxt;
         dout     <= dout_nxt;
         dout_vld <= dout_vld_nxt;
         ferr     <= ferr_nxt;
         ovr      <= ovr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      bit_idx_nxt  = bit_idx;
      shreg_nxt    = shreg;
      dout_nxt     = dout;
      // An accept clears valid unless a new byte loads on the same edge.
      dout_vld_nxt = dout_vld & ~dout_rdy;
      ferr_nxt     = 1'b0;
      ovr_nxt      = 1'b0;

      case (state)
         IDLE: begin
            if (!rxd_s) begin
               state_nxt = START;
               cnt_nxt   = HALF_TC;
            end
         end
         START: begin
            if (cnt == '0) begin
               if (!rxd_s) begin
                  state_nxt   = DATA;
                  cnt_nxt     = FULL_TC;
                  bit_idx_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         DATA: begin
            if (cnt == '0) begin
               shreg_nxt[bit_idx] = rxd_s;
               cnt_nxt            = FULL_TC;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         STOP: begin
            if (cnt == '0) begin
               // Returning at mid-stop-bit leaves time to catch a
               // back-to-back start bit.
               state_nxt = IDLE;
               if (rxd_s) begin
                  if (!dout_vld || dout_rdy) begin
                     dout_nxt     = shreg;
                     dout_vld_nxt = 1'b1;
                  end else begin
                     ovr_nxt = 1'b1;
                  end
               end else begin
                  ferr_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte: drives 8N1 frames on rxd at DIV=16 and
// compares delivered bytes and error pulses against a frame-level model.
module tb_uart_rx_byte;

   localparam int DIV = 16;
   // rxd fall to dout_vld visible: 3 sync/detect + DIV/2 + 9*DIV
   localparam int LAT = 9 * DIV + DIV / 2 + 3;
   localparam int STOP_C = 9 * DIV + DIV / 2 + 2;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rxd = 1'b1;
   logic       dout_rdy = 1'b0;
   logic [7:0] dout;
   logic       dout_vld, busy, ferr, ovr;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int t_fall = 0;

   // monitor-owned
   byte unsigned got_q[$];
   int ferr_seen = 0, ovr_seen = 0, both_seen = 0, vld_hi = 0;
   int vld_rise_cyc = -1;
   logic vld_prev = 1'b0;

   // model-owned
   byte unsigned exp_q[$];
   int  exp_ferr = 0, exp_ovr = 0, cmp_rd = 0;
   bit  m_held = 1'b0;
   byte unsigned m_dout = 8'h00;

   uart_rx_byte #(.DIV(DIV)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .rxd      (rxd),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_rdy (dout_rdy),
      .busy     (busy),
      .ferr     (ferr),
      .ovr      (ovr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dout_vld && dout_rdy && rstn) got_q.push_back(dout);
      if (ferr) ferr_seen++;
      if (ovr) ovr_seen++;
      if (ferr && ovr) both_seen++;
      if (dout_vld) vld_hi++;
      if (dout_vld && !vld_prev) vld_rise_cyc = cyc;
      vld_prev = dout_vld;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_q(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = cmp_rd; i < exp_q.size(); i++)
         if (i < got_q.size()) check({tag, "_byte"}, got_q[i], exp_q[i]);
      cmp_rd = exp_q.size();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one frame, one cycle per iteration; ncyc < 10*DIV truncates it.
   // rdy_pulse raises dout_rdy for exactly the stop-sample edge.
   task automatic send(input logic [7:0] b, input logic stop, input bit rdy_pulse, input int ncyc);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      t_fall = cyc;
      for (int c = 0; c < ncyc; c++) begin
         rxd = fr[c / DIV];
         if (rdy_pulse && c == STOP_C) dout_rdy = 1'b1;
         if (rdy_pulse && c == STOP_C + 1) dout_rdy = 1'b0;
         @(posedge clk);
         #1;
      end
      rxd = 1'b1;
   endtask

   // Frame-level reference: what the consumer should see given the stop
   // bit and whether dout_rdy is high at / right after the stop sample.
   task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit rdy_at_stop,
                              input bit rdy_after);
      if (!stop_ok) exp_ferr++;
      else if (!m_held || rdy_at_stop) begin
         if (m_held) exp_q.push_back(m_dout);
         m_dout = b;
         m_held = 1'b1;
      end else exp_ovr++;
      if (m_held && rdy_after) begin
         exp_q.push_back(m_dout);
         m_held = 1'b0;
      end
   endtask

   initial begin
      int h0, f0;
      logic [7:0] b;
      bit bad;

      rstn = 1'b0;
      idle(4);
      check("rst_dout", dout, 8'h00);
      check("rst_vld", dout_vld, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ferr", ferr, 1'b0);
      check("rst_ovr", ovr, 1'b0);
      rstn = 1'b1;
      idle(5);

      // single byte, latency and one-cycle valid pulse
      dout_rdy = 1'b1;
      h0 = vld_hi;
      send(8'hA5, 1'b1, 1'b0, 10 * DIV);
      model_frame(8'hA5, 1'b1, 1'b1, 1'b1);
      idle(4);
      check("a5_latency", vld_rise_cyc - t_fall, LAT);
      check("a5_vld_width", vld_hi - h0, 1);
      check("a5_dout_hold", dout, 8'hA5);
      check_q("a5");
      check("a5_ferr", ferr_seen, exp_ferr);
      check("a5_ovr", ovr_seen, exp_ovr);

      // back-to-back, zero idle
      send(8'h00, 1'b1, 1'b0, 10 * DIV); model_frame(8'h00, 1'b1, 1'b1, 1'b1);
      send(8'hFF, 1'b1, 1'b0, 10 * DIV); model_frame(8'hFF, 1'b1, 1'b1, 1'b1);
      send(8'h3C, 1'b1, 1'b0, 10 * DIV); model_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      idle(4);
      check_q("b2b");

      // random bytes, random bad stop bits, random gaps
      for (int i = 0; i < 14; i++) begin
         b = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         send(b, !bad, 1'b0, 10 * DIV);
         model_frame(b, !bad, 1'b1, 1'b1);
         if (bad) idle(2 * DIV);
         else idle($urandom_range(0, 5));
      end
      idle(4);
      check_q("rand");
      check("rand_ferr", ferr_seen, exp_ferr);
      check("rand_ovr", ovr_seen, exp_ovr);

      // framing error then good frame
      h0 = vld_hi;
      send(8'h5A, 1'b0, 1'b0, 10 * DIV); model_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      idle(2 * DIV);
      check("ferr_pulse", ferr_seen, exp_ferr);
      check("ferr_no_vld", vld_hi - h0, 0);
      send(8'h5A, 1'b1, 1'b0, 10 * DIV); model_frame(8'h5A, 1'b1, 1'b1, 1'b1);
      idle(4);
      check_q("after_ferr");

      // overrun with consumer stalled
      dout_rdy = 1'b0;
      send(8'h11, 1'b1, 1'b0, 10 * DIV); model_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send(8'h22, 1'b1, 1'b0, 10 * DIV); model_frame(8'h22, 1'b1, 1'b0, 1'b0);
      idle(4);
      check("ovr_dout", dout, 8'h11);
      check("ovr_vld", dout_vld, 1'b1);
      check("ovr_count", ovr_seen, exp_ovr);
      dout_rdy = 1'b1;
      idle(1);
      dout_rdy = 1'b0;
      if (m_held) begin exp_q.push_back(m_dout); m_held = 1'b0; end
      idle(2);
      check("ovr_vld_drop", dout_vld, 1'b0);
      check("ovr_dout_keep", dout, 8'h11);
      check_q("ovr");

      // accept on the very stop-sample edge of the second byte
      send(8'h11, 1'b1, 1'b0, 10 * DIV); model_frame(8'h11, 1'b1, 1'b0, 1'b0);
      send(8'h22, 1'b1, 1'b1, 10 * DIV); model_frame(8'h22, 1'b1, 1'b1, 1'b0);
      idle(4);
      check("edge_dout", dout, 8'h22);
      check("edge_vld", dout_vld, 1'b1);
      check("edge_no_ovr", ovr_seen, exp_ovr);
      check_q("edge");

      // start-bit glitch, 4 cycles low
      f0 = ferr_seen;
      rxd = 1'b0;
      idle(4);
      rxd = 1'b1;
      idle(3);
      check("glitch_busy_hi", busy, 1'b1);
      idle(10);
      check("glitch_busy_lo", busy, 1'b0);
      check("glitch_no_ferr", ferr_seen - f0, 0);
      check("glitch_dout", dout, 8'h22);
      check_q("glitch");

      // reset during data bit 3, then a clean frame
      send(8'hE7, 1'b1, 1'b0, 4 * DIV + DIV / 2);
      check("pre_rst_busy", busy, 1'b1);
      rstn = 1'b0;
      idle(3);
      check("mid_rst_dout", dout, 8'h00);
      check("mid_rst_vld", dout_vld, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_ferr", ferr, 1'b0);
      check("mid_rst_ovr", ovr, 1'b0);
      m_held = 1'b0;
      m_dout = 8'h00;
      rstn = 1'b1;
      dout_rdy = 1'b1;
      idle(3);
      send(8'hC3, 1'b1, 1'b0, 10 * DIV); model_frame(8'hC3, 1'b1, 1'b1, 1'b1);
      idle(4);
      check("c3_dout", dout, 8'hC3);
      check_q("c3");
      check("final_ferr", ferr_seen, exp_ferr);
      check("final_ovr", ovr_seen, exp_ovr);
      check("never_both", both_seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
